corner_reader: RTL and testbench
================================

Name: corner_reader

Overview:
- Read-side consumer of the two per-camera corner FIFOs: 128-bit corner records, first-word-fall-through, in the read-clock domain.
- Arbitrates round-robin between camera 0 and camera 1 and drains records in bursts.
- Serializes each burst into a 32-bit valid/ready word stream for the host DMA/SPI path.
- Each burst is one header word followed by 4 words per record.

Parameters:
- MAX_BURST, 16: maximum records per burst. Legal range 1..255.
- HDR_TAG, 8'hA5: tag placed in header word bits [31:24].

Ports:
- c  in  1  clock (corner FIFO read clock)
- r_n  in  1  asynchronous active-low reset
- en  in  1  enable; gates only the start of new bursts
- q  in  256  FIFO heads; [127:0] = cam 0, [255:128] = cam 1
- q_empty  in  2  per-camera FIFO empty
- q_avail  in  14  per-camera fill level; [6:0] = cam 0, [13:7] = cam 1
- q_read  out  2  per-camera pop strobe, one cycle
- out_d  out  32  stream data
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready from sink
- out_last  out  1  final word of burst
- busy  out  1  high whenever state is not IDLE
- rec_count  out  64  records popped; [31:0] = cam 0, [63:32] = cam 1

Behaviour:
- Reset (r_n low, asynchronous):
  - state IDLE.
  - q_read = 0, out_valid = 0, out_last = 0, out_d = 0, busy = 0.
  - rec_count = 0.
  - Round-robin pointer = 0, so cam 0 has priority first.
- Reset asserted mid-burst aborts the burst immediately. No further pops occur; partial output is discarded by the sink.
- FIFO contract (FWFT):
  - q slice is valid whenever q_empty[k] = 0.
  - q_read[k] high for one cycle pops that FIFO; the new head is valid from the following cycle.
  - The block never asserts q_read[k] while q_empty[k] = 1.
- Stream contract:
  - A word transfers on a cycle where out_valid and out_ready are both high.
  - Once out_valid is high, out_d, out_valid and out_last hold stable until the transfer.
- States: IDLE, HDR, WORD, GAP.
- IDLE:
  - A camera k is eligible when en = 1 and q_empty[k] = 0.
  - If both are eligible, pick the camera not served last (pointer); otherwise pick the one eligible camera.
  - Latch cam = k. Latch n = min(max(q_avail[k], 1), MAX_BURST), computed with 8-bit arithmetic.
  - Set remaining = n and go to HDR. IDLE to HDR takes 1 cycle.
- HDR:
  - out_valid = 1.
  - out_d = {HDR_TAG, 7'b0, cam, 8'h00, n[7:0]}.
  - On transfer: idx = 0, go to WORD.
- WORD:
  - out_valid = 1.
  - out_d = record word idx, MSW first: idx 0 = bits [127:96], idx 3 = bits [31:0] of the cam slice.
  - On transfer with idx < 3: idx++.
  - On transfer with idx = 3:
    - q_read[cam] pulses in the same cycle.
    - rec_count[cam] increments, wrapping at 2^32.
    - remaining decrements.
    - If remaining was 1: out_last was high on this word, pointer toggles to the other camera, go to IDLE.
    - Otherwise go to GAP.
- GAP:
  - out_valid = 0, for exactly 1 cycle while the FIFO head updates.
  - Then idx = 0, go to WORD.
- en deasserted mid-burst does not truncate; the latched n records are always emitted.
- n never exceeds the latched q_avail (minimum 1 when q_empty = 0), so the FIFO never underflows within a burst.
- Minimum burst length: 1 + 5n − 1 cycles with out_ready held high.
- Output signals are registered; q_read is combinational from the transfer condition.

Test Plan:
- Single record: cam 0 holds one record 128'h0123..CDEF (q_avail = 1), out_ready = 1.
  - Header 32'hA500_0001, then words 0123…, …, …CDEF.
  - out_last on word 4; q_read[0] pulses once; rec_count[31:0] = 1.
- Burst cap: cam 1 with q_avail = 40.
  - First burst header 32'hA501_0010 (n = 16), 64 data words, 15 GAP bubbles.
  - Then IDLE, then a second burst.
- Arbitration: both FIFOs hold 3 records each with q_avail = 3.
  - Bursts alternate cam 0 then cam 1.
  - Headers 32'hA500_0003 then 32'hA501_0003.
- Backpressure: toggle out_ready pseudo-randomly during a 2-record burst.
  - out_d is stable while stalled; exactly 9 transfers; exactly 2 q_read pulses, each coincident with a word-3 transfer.
- Enable and reset:
  - en low with data present: no output.
  - en dropped after the header: full burst still emitted.
  - r_n pulsed low after 2 words: outputs reach reset values asynchronously, no pop, rec_count = 0.
- Zero-avail corner case: q_empty = 0 with q_avail = 0 gives header n = 1 and exactly one record drained.

Source files
------------

// File: rtl/corner_reader.sv
// Drains the two per-camera FWFT corner FIFOs round-robin and serializes each
// burst as one header word plus four 32-bit words per 128-bit record.
module corner_reader #(
    parameter int unsigned MAX_BURST = 16,
    parameter logic [7:0]  HDR_TAG   = 8'hA5
) (
    input  logic         c,
    input  logic         r_n,
    input  logic         en,
    input  logic [255:0] q,
    input  logic [1:0]   q_empty,
    input  logic [13:0]  q_avail,
    output logic [1:0]   q_read,
    output logic [31:0]  out_d,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         busy,
    output logic [63:0]  rec_count
);
    typedef enum logic [1:0] {IDLE, HDR, WORD, GAP} state_t;

    localparam logic [7:0] MAXB = 8'(MAX_BURST);

    state_t          state_q;
    logic            cam_q;
    logic            ptr_q;
    logic [7:0]      rem_q;
    logic [1:0]      idx_q;
    logic [31:0]     out_d_q;
    logic            valid_q;
    logic            last_q;
    logic            busy_q;
    logic [1:0][31:0] cnt_q;

    logic [1:0]   elig;
    logic         pick;
    logic [7:0]   avail8;
    logic [7:0]   n_sel;
    logic [127:0] rec;
    logic         xfer;
    logic         rec_done;

    function automatic logic [31:0] word_of(input logic [127:0] r, input logic [1:0] i);
        logic [31:0] w;
        case (i)
            2'd0:    w = r[127:96];
            2'd1:    w = r[95:64];
            2'd2:    w = r[63:32];
            default: w = r[31:0];
        endcase
        return w;
    endfunction

    always_comb begin
        elig   = {2{en}} & ~q_empty;
        pick   = (elig == 2'b11) ? ptr_q : elig[1];
        avail8 = {1'b0, (pick ? q_avail[13:7] : q_avail[6:0])};
        // A non-empty FIFO reporting zero fill still holds at least one record.
        if (avail8 == 8'd0)
            avail8 = 8'd1;
        n_sel    = (avail8 > MAXB) ? MAXB : avail8;
        rec      = cam_q ? q[255:128] : q[127:0];
        xfer     = valid_q & out_ready;
        rec_done = (state_q == WORD) && xfer && (idx_q == 2'd3);
        q_read   = rec_done ? (cam_q ? 2'b10 : 2'b01) : 2'b00;
    end

    always_ff @(posedge c or negedge r_n) begin
        if (!r_n) begin
            state_q <= IDLE;
            cam_q   <= 1'b0;
            ptr_q   <= 1'b0;
            rem_q   <= 8'd0;
            idx_q   <= 2'd0;
            out_d_q <= 32'd0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|elig) begin
                        cam_q   <= pick;
                        rem_q   <= n_sel;
                        out_d_q <= {HDR_TAG, 7'd0, pick, 8'h00, n_sel};
                        valid_q <= 1'b1;
                        last_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= HDR;
                    end
                end
                HDR: begin
                    if (xfer) begin
                        idx_q   <= 2'd0;
                        out_d_q <= word_of(rec, 2'd0);
                        last_q  <= 1'b0;
                        state_q <= WORD;
                    end
                end
                WORD: begin
                    if (xfer) begin
                        if (idx_q != 2'd3) begin
                            idx_q   <= idx_q + 2'd1;
                            out_d_q <= word_of(rec, idx_q + 2'd1);
                            last_q  <= (idx_q == 2'd2) && (rem_q == 8'd1);
                        end else begin
                            cnt_q[cam_q] <= cnt_q[cam_q] + 32'd1;
                            rem_q   <= rem_q - 8'd1;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            if (rem_q == 8'd1) begin
                                ptr_q   <= ~cam_q;
                                busy_q  <= 1'b0;
                                state_q <= IDLE;
                            end else begin
                                state_q <= GAP;
                            end
                        end
                    end
                end
                GAP: begin
                    // Popped head is now visible; restart at the next record's MSW.
                    idx_q   <= 2'd0;
                    out_d_q <= word_of(rec, 2'd0);
                    valid_q <= 1'b1;
                    last_q  <= 1'b0;
                    state_q <= WORD;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_d     = out_d_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign busy      = busy_q;
    assign rec_count = cnt_q;
endmodule

// File: tb/tb_corner_reader.sv
// Self-checking bench for corner_reader: FWFT FIFO models, burst-level reference
// model of the expected word stream, vector table, corner sequences and random runs.
module tb_corner_reader;
    localparam int MAXB = 16;

    logic         c = 1'b0;
    logic         r_n;
    logic         en;
    logic [255:0] q;
    logic [1:0]   q_empty;
    logic [13:0]  q_avail;
    logic [1:0]   q_read;
    logic [31:0]  out_d;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic         busy;
    logic [63:0]  rec_count;

    corner_reader #(.MAX_BURST(MAXB), .HDR_TAG(8'hA5)) dut (
        .c(c), .r_n(r_n), .en(en), .q(q), .q_empty(q_empty), .q_avail(q_avail),
        .q_read(q_read), .out_d(out_d), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .rec_count(rec_count)
    );

    always #5 c = ~c;

    int checks = 0;
    int errs   = 0;
    int cyc    = 0;
    int pops   = 0;
    int tot0   = 0;
    int tot1   = 0;
    int avail_ovr = -1;
    bit rdy_rand  = 1'b0;
    bit mon_on    = 1'b0;
    logic [1:0] pend = 2'b00;

    logic [127:0] fq0[$], fq1[$], mq0[$], mq1[$];
    logic [32:0]  expq[$], obs[$];
    int           obs_cyc[$];

    int          k = 0;
    bit          cur_cam = 1'b0;
    bit          stall_q = 1'b0;
    logic [32:0] prev_w = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] rnd();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic drive_fifo();
        int a0, a1;
        a0 = (fq0.size() > 127) ? 127 : fq0.size();
        a1 = (fq1.size() > 127) ? 127 : fq1.size();
        if (avail_ovr >= 0) begin
            if (fq0.size() > 0) a0 = avail_ovr;
            if (fq1.size() > 0) a1 = avail_ovr;
        end
        q[127:0]   = (fq0.size() > 0) ? fq0[0] : '0;
        q[255:128] = (fq1.size() > 0) ? fq1[0] : '0;
        q_empty    = {fq1.size() == 0, fq0.size() == 0};
        q_avail    = {7'(a1), 7'(a0)};
    endtask

    task automatic push(input bit cam, input logic [127:0] r, input bit to_model);
        if (cam) begin
            fq1.push_back(r);
            if (to_model) mq1.push_back(r);
        end else begin
            fq0.push_back(r);
            if (to_model) mq0.push_back(r);
        end
        drive_fifo();
    endtask

    // FWFT FIFOs: a pop seen at the edge shows the new head just after it.
    always @(negedge c) pend = q_read;
    always @(posedge c) begin
        cyc++;
        #1;
        if (pend[0] && fq0.size() > 0) void'(fq0.pop_front());
        if (pend[1] && fq1.size() > 0) void'(fq1.pop_front());
        pend = 2'b00;
        if (rdy_rand) out_ready = ($urandom_range(0, 99) < 60);
        drive_fifo();
    end

    // Stream monitor: capture transfers, check hold-while-stalled and pop placement.
    always @(negedge c) begin
        logic [1:0] er;
        bit xf;
        if (mon_on) begin
            xf = out_valid && out_ready;
            if (stall_q) chk("hold", 64'({out_valid, out_last, out_d}), 64'({1'b1, prev_w}));
            er = (xf && k > 0 && (k % 4) == 0) ? (cur_cam ? 2'b10 : 2'b01) : 2'b00;
            chk("q_read", 64'(q_read), 64'(er));
            if (xf) begin
                if (k == 0) cur_cam = out_d[16];
                obs.push_back({out_last, out_d});
                obs_cyc.push_back(cyc);
                if (q_read != 2'b00) pops++;
                k = out_last ? 0 : k + 1;
            end
            stall_q = out_valid && !out_ready;
            prev_w  = {out_last, out_d};
        end
    end

    task automatic mon_clear();
        obs.delete();
        obs_cyc.delete();
        k = 0;
        stall_q = 1'b0;
        pops = 0;
    endtask

    task automatic do_reset();
        mon_on = 1'b0;
        rdy_rand = 1'b0;
        en = 1'b0;
        out_ready = 1'b0;
        avail_ovr = -1;
        fq0.delete(); fq1.delete(); mq0.delete(); mq1.delete(); expq.delete();
        drive_fifo();
        r_n = 1'b0;
        pend = 2'b00;
        repeat (2) @(posedge c);
        #2 r_n = 1'b1;
        mon_clear();
    endtask

    // Burst-level reference: who goes next, how many records, what words appear.
    task automatic build_model();
        bit ptr, cam;
        int sz, av, n;
        logic [127:0] r;
        ptr = 1'b0;
        expq.delete();
        tot0 = 0;
        tot1 = 0;
        while (mq0.size() > 0 || mq1.size() > 0) begin
            if (mq0.size() > 0 && mq1.size() > 0) cam = ptr;
            else cam = (mq1.size() > 0);
            sz = cam ? mq1.size() : mq0.size();
            av = (avail_ovr >= 0) ? avail_ovr : ((sz > 127) ? 127 : sz);
            n  = (av < 1) ? 1 : av;
            if (n > MAXB) n = MAXB;
            expq.push_back({1'b0, 8'hA5, 7'd0, cam, 8'h00, 8'(n)});
            for (int i = 0; i < n; i++) begin
                r = cam ? mq1.pop_front() : mq0.pop_front();
                if (cam) tot1++; else tot0++;
                for (int w = 0; w < 4; w++)
                    expq.push_back({(i == n - 1) && (w == 3), r[127 - 32*w -: 32]});
            end
            ptr = !cam;
        end
    endtask

    task automatic cmp_stream(input string nm);
        chk({nm, "_len"}, 64'(obs.size()), 64'(expq.size()));
        for (int i = 0; i < expq.size() && i < obs.size(); i++) begin
            chk($sformatf("%s_w%0d", nm, i), 64'(obs[i]), 64'(expq[i]));
            if (obs[i] !== expq[i]) break;
        end
        chk({nm, "_pops"}, 64'(pops), 64'(tot0 + tot1));
        chk({nm, "_reccnt"}, rec_count, {32'(tot1), 32'(tot0)});
        chk({nm, "_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic run_stream(input string nm, input bit rr);
        int budget;
        build_model();
        mon_clear();
        mon_on = 1'b1;
        out_ready = 1'b1;
        rdy_rand = rr;
        en = 1'b1;
        budget = 20 * expq.size() + 50;
        while (obs.size() < expq.size() && budget > 0) begin
            @(posedge c);
            budget--;
        end
        repeat (15) @(posedge c);
        en = 1'b0;
        rdy_rand = 1'b0;
        @(negedge c);
        mon_on = 1'b0;
        cmp_stream(nm);
    endtask

    typedef struct {
        int          n0;
        int          n1;
        int          ovr;
        bit          rr;
        logic [31:0] hdr;
        int          bursts;
    } vec_t;

    initial begin
        vec_t tbl[7];
        int   nl, nf, budget, n0, n1;
        string nm;

        tbl[0] = '{1,   0, -1, 1'b0, 32'hA500_0001, 1};
        tbl[1] = '{0,  40, -1, 1'b0, 32'hA501_0010, 3};
        tbl[2] = '{3,   3, -1, 1'b0, 32'hA500_0003, 2};
        tbl[3] = '{1,   0,  0, 1'b0, 32'hA500_0001, 1};
        tbl[4] = '{0, 127, -1, 1'b0, 32'hA501_0010, 8};
        tbl[5] = '{2,   0, -1, 1'b1, 32'hA500_0002, 1};
        tbl[6] = '{3,   0,  0, 1'b0, 32'hA500_0001, 3};

        en = 1'b0;
        out_ready = 1'b0;
        r_n = 1'b0;
        drive_fifo();
        #3;
        chk("rst_outs", 64'({q_read, out_valid, out_last, busy, out_d}), 64'd0);
        chk("rst_reccnt", rec_count, 64'd0);

        for (int i = 0; i < 7; i++) begin
            do_reset();
            avail_ovr = tbl[i].ovr;
            for (int j = 0; j < tbl[i].n0; j++)
                push(1'b0, (j == 0) ? 128'h01234567_89ABCDEF_01234567_89ABCDEF : rnd(), 1'b1);
            for (int j = 0; j < tbl[i].n1; j++)
                push(1'b1, rnd(), 1'b1);
            nm = $sformatf("vec%0d", i);
            run_stream(nm, tbl[i].rr);
            chk({nm, "_hdr"}, 64'((obs.size() > 0) ? obs[0][31:0] : 32'd0), 64'(tbl[i].hdr));
            nl = 0;
            foreach (obs[j]) if (obs[j][32]) nl++;
            chk({nm, "_bursts"}, 64'(nl), 64'(tbl[i].bursts));
            nf = int'(tbl[i].hdr[7:0]);
            if (!tbl[i].rr && obs.size() > 4 * nf) begin
                chk({nm, "_cycles"}, 64'(obs_cyc[4*nf] - obs_cyc[0] + 1), 64'(5 * nf));
                if (obs.size() > 4 * nf + 1)
                    chk({nm, "_idle"}, 64'(obs_cyc[4*nf+1] - obs_cyc[4*nf]), 64'd2);
            end
        end

        // en low with data present: nothing may start.
        do_reset();
        push(1'b0, rnd(), 1'b0);
        push(1'b0, rnd(), 1'b0);
        out_ready = 1'b1;
        mon_on = 1'b1;
        repeat (20) @(posedge c);
        @(negedge c);
        mon_on = 1'b0;
        chk("enlow_xfers", 64'(obs.size()), 64'd0);
        chk("enlow_outs", 64'({busy, out_valid}), 64'd0);
        chk("enlow_fifo", 64'(fq0.size()), 64'd2);

        // en dropped while the header is up: whole burst still drains, no new burst.
        do_reset();
        for (int j = 0; j < 3; j++) push(1'b0, rnd(), 1'b1);
        for (int j = 0; j < 2; j++) push(1'b1, rnd(), 1'b0);
        build_model();
        mon_clear();
        mon_on = 1'b1;
        out_ready = 1'b1;
        en = 1'b1;
        budget = 20;
        while (obs.size() < 1 && budget > 0) begin
            @(posedge c);
            budget--;
        end
        en = 1'b0;
        repeat (40) @(posedge c);
        @(negedge c);
        mon_on = 1'b0;
        cmp_stream("endrop");
        chk("endrop_cam1", 64'(fq1.size()), 64'd2);

        // Reset pulsed after two transferred words: async clear, no pop.
        do_reset();
        push(1'b0, rnd(), 1'b0);
        push(1'b0, rnd(), 1'b0);
        mon_on = 1'b1;
        out_ready = 1'b1;
        en = 1'b1;
        budget = 30;
        while (obs.size() < 2 && budget > 0) begin
            @(posedge c);
            budget--;
        end
        mon_on = 1'b0;
        chk("rstmid_words", 64'(obs.size()), 64'd2);
        #2 r_n = 1'b0;
        #1;
        chk("rstmid_outs", 64'({q_read, out_valid, out_last, busy, out_d}), 64'd0);
        chk("rstmid_reccnt", rec_count, 64'd0);
        chk("rstmid_fifo", 64'(fq0.size()), 64'd2);
        en = 1'b0;
        @(posedge c);
        #2 r_n = 1'b1;

        // Randomized traffic against the reference model.
        for (int it = 0; it < 8; it++) begin
            do_reset();
            avail_ovr = ($urandom_range(0, 3) == 0) ? 0 : -1;
            n0 = $urandom_range(0, 24);
            n1 = $urandom_range(0, 24);
            for (int j = 0; j < n0; j++) push(1'b0, rnd(), 1'b1);
            for (int j = 0; j < n1; j++) push(1'b1, rnd(), 1'b1);
            run_stream($sformatf("rnd%0d", it), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errs);
        $finish;
    end
endmodule
